truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Sequencer for the selectable boolean-expression evaluator (x,y,w,z,letra -> s).
//  On start it walks every input combination for NUM_SEL consecutive selector codes and
//  samples s into one truth-table word per selector. Each word is published with a 1-cycle valid.
//  Replaces hand-written #1 stimulus lists with a clocked, self-timed sweep.
// PARAMETERS
//  NVARS     3     variables swept; legal 3 ({x,y,z}, w held 0) or 4 ({x,y,w,z}); TT_W = 2**NVARS
//  FIRST_SEL 4'hA  first letra code driven
//  NUM_SEL   2     selector codes swept: FIRST_SEL .. FIRST_SEL+NUM_SEL-1, 4-bit wrap; 1..16
//  SETTLE    1     cycles each combination is held before s is sampled; >=1
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      synchronous, active-high
//  start    in   1      begin sweep; sampled only in IDLE
//  s        in   1      evaluator output
//  x,y,w,z  out  1      evaluator inputs, registered
//  letra    out  4      evaluator selector, registered
//  busy     out  1      high from the cycle after accepted start until DONE
//  tt_valid out  1      1-cycle pulse: tt_data/tt_sel hold a complete table
//  tt_sel   out  4      selector code tt_data belongs to
//  tt_data  out  TT_W   bit[i] = s sampled with input index i; x is MSB of i
//  done     out  1      1-cycle pulse at end of sweep
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; idx=0; sel_cnt=0; letra=0; busy=done=tt_valid=0.
//  FSM: IDLE -> DRIVE -> SAMPLE -> (DRIVE | EMIT); EMIT -> (DRIVE | DONE); DONE -> IDLE.
//  IDLE: start=1 -> load letra=FIRST_SEL, idx=0, tt_data=0, drive vars=0; busy=1 next cycle.
//  DRIVE: vars = idx ({x,y,z}=idx[2:0], w=0 if NVARS=3; {x,y,w,z}=idx if 4); held SETTLE cycles.
//  SAMPLE: tt_data[idx] <= s at this edge. If idx<TT_W-1: idx++, -> DRIVE. Else -> EMIT.
//  Cost: SETTLE+1 cycles per combination; vars never change inside a combination window.
//  EMIT: tt_valid=1 for 1 cycle; tt_sel = current letra. If sel_cnt<NUM_SEL-1: letra++ (4-bit wrap),
//   sel_cnt++, idx=0, tt_data cleared on entering DRIVE -> DRIVE. Else -> DONE.
//  tt_data/tt_sel hold their last EMIT values until the next sweep clears tt_data.
//  DONE: done=1 for 1 cycle; busy=0 in that same cycle; -> IDLE.
//  Latency: start accepted -> done high = NUM_SEL*(TT_W*(SETTLE+1)+1)+1 cycles.
//   Defaults: 2*(8*2+1)+1 = 35.
//  start while busy or in DONE: ignored, not queued. start held high: new sweep begins at the next IDLE.
//  reset mid-sweep: immediate return to reset values; partial table discarded; no tt_valid/done.
//  s unknown (x/z) at a sample edge: stored as-is; the caller must drive known values.
// CONFIGURATION
//  SWEEP_COMPARE_EN defined: adds ports
//   exp_data in TT_W   expected table, sampled in EMIT
//   tt_match out 1     valid with tt_valid: (tt_data==exp_data)
//   err      out 1     sticky OR of ~tt_match over the sweep; cleared on accepted start and on reset
//  SWEEP_COMPARE_EN undefined: these ports and their logic are absent; all other behaviour identical.
// TESTING
//  1 reset, idle 5 cycles -> all outputs 0, busy=0, no pulses.
//  2 Defaults with the reference evaluator, pulse start.
//    -> tt_valid#1: tt_sel=A, tt_data=8'hC3 (x XNOR y).
//    -> tt_valid#2: tt_sel=B, tt_data=8'h00.
//    -> done 35 cycles after start.
//  3 Pulse start during the sweep at cycle 10 -> ignored; exactly 2 tt_valid and 1 done.
//  4 reset at cycle 12 of a sweep -> outputs 0 the next cycle; no tt_valid; new start -> full 35-cycle sweep.
//  5 NVARS=4, SETTLE=2, NUM_SEL=1, FIRST_SEL=4'hF, s tied to z.
//    -> tt_sel=F, tt_data=16'hAAAA; done 1*(16*3+1)+1 = 50 cycles after start.
//  6 SWEEP_COMPARE_EN, exp_data=8'hC3 -> table A: tt_match=1; table B: tt_match=0; err=1 at done.
//    -> err cleared by the next accepted start.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Self-timed sweeper: walks every input combination of the boolean evaluator for a run of
// selector codes and captures one truth table per code. Optional checker: SWEEP_COMPARE_EN.
module truth_table_sweeper #(
    parameter int         NVARS     = 3,
    parameter logic [3:0] FIRST_SEL = 4'hA,
    parameter int         NUM_SEL   = 2,
    parameter int         SETTLE    = 1,
    localparam int        TT_W      = 2 ** NVARS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            s,
`ifdef SWEEP_COMPARE_EN
    input  logic [TT_W-1:0] exp_data,
    output logic            tt_match,
    output logic            err,
`endif
    output logic            x,
    output logic            y,
    output logic            w,
    output logic            z,
    output logic [3:0]      letra,
    output logic            busy,
    output logic            tt_valid,
    output logic [3:0]      tt_sel,
    output logic [TT_W-1:0] tt_data,
    output logic            done
);

    localparam int               CW       = $clog2(SETTLE + 1);
    localparam logic [NVARS-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, EMIT, DONE} state_t;

    state_t           state;
    logic [NVARS-1:0] idx;
    logic [4:0]       sel_cnt;
    logic [CW-1:0]    settle_cnt;
    logic [3:0]       vars;

    // Three-variable mode keeps w at 0 and spreads the index over {x,y,z}.
    function automatic logic [3:0] map_vars(input logic [NVARS-1:0] i);
        logic [3:0] e;
        e = 4'(i);
        return (NVARS == 4) ? e : (((e << 1) & 4'b1100) | (e & 4'b0001));
    endfunction

    assign {x, y, w, z} = vars;

`ifdef SWEEP_COMPARE_EN
    assign tt_match = tt_valid & (tt_data == exp_data);
`endif

    // NOTE: every register here is state, so all updates use <=; blocking writes would let
    // later statements in the same edge see half-updated values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            sel_cnt    <= '0;
            settle_cnt <= '0;
            vars       <= '0;
            letra      <= '0;
            busy       <= 1'b0;
            tt_valid   <= 1'b0;
            tt_sel     <= '0;
            tt_data    <= '0;
            done       <= 1'b0;
`ifdef SWEEP_COMPARE_EN
            err        <= 1'b0;
`endif
        end else begin
            tt_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= DRIVE;
                    letra      <= FIRST_SEL;
                    idx        <= '0;
                    sel_cnt    <= '0;
                    settle_cnt <= '0;
                    tt_data    <= '0;
                    vars       <= map_vars('0);
                    busy       <= 1'b1;
`ifdef SWEEP_COMPARE_EN
                    err        <= 1'b0;
`endif
                end
                DRIVE: begin
                    if (settle_cnt == CW'(SETTLE - 1)) state <= SAMPLE;
                    else settle_cnt <= settle_cnt + 1'b1;
                end
                SAMPLE: begin
                    tt_data[idx] <= s;
                    settle_cnt   <= '0;
                    if (idx != IDX_LAST) begin
                        idx   <= idx + 1'b1;
                        vars  <= map_vars(idx + 1'b1);
                        state <= DRIVE;
                    end else begin
                        tt_valid <= 1'b1;
                        tt_sel   <= letra;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
`ifdef SWEEP_COMPARE_EN
                    err <= err | (tt_data != exp_data);
`endif
                    if (sel_cnt < 5'(NUM_SEL - 1)) begin
                        letra   <= letra + 1'b1;
                        sel_cnt <= sel_cnt + 1'b1;
                        idx     <= '0;
                        tt_data <= '0;
                        vars    <= map_vars('0);
                        state   <= DRIVE;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: default sweep with a scoreboard of expected tables, plus a
// 4-variable instance. Compare-port checks are included when SWEEP_COMPARE_EN is defined.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, s;
    logic       x, y, w, z, busy, tt_valid, done;
    logic [3:0] letra, tt_sel;
    logic [7:0] tt_data;

    logic        reset4, start4, s4;
    logic        x4, y4, w4, z4, busy4, tt_valid4, done4;
    logic [3:0]  letra4, tt_sel4;
    logic [15:0] tt_data4;

`ifdef SWEEP_COMPARE_EN
    logic [7:0]  exp_data = 8'hC3;
    logic        tt_match, err;
    logic [15:0] exp_data4 = 16'hAAAA;
    logic        tt_match4, err4;
`endif

    // Reference evaluator: code A is x XNOR y, code B is constant 0.
    assign s  = (letra == 4'hA) ? ~(x ^ y) : 1'b0;
    assign s4 = z4;

    truth_table_sweeper u_dut (
        .clk(clk), .reset(reset), .start(start), .s(s),
`ifdef SWEEP_COMPARE_EN
        .exp_data(exp_data), .tt_match(tt_match), .err(err),
`endif
        .x(x), .y(y), .w(w), .z(z), .letra(letra), .busy(busy),
        .tt_valid(tt_valid), .tt_sel(tt_sel), .tt_data(tt_data), .done(done)
    );

    truth_table_sweeper #(.NVARS(4), .FIRST_SEL(4'hF), .NUM_SEL(1), .SETTLE(2)) u_dut4 (
        .clk(clk), .reset(reset4), .start(start4), .s(s4),
`ifdef SWEEP_COMPARE_EN
        .exp_data(exp_data4), .tt_match(tt_match4), .err(err4),
`endif
        .x(x4), .y(y4), .w(w4), .z(z4), .letra(letra4), .busy(busy4),
        .tt_valid(tt_valid4), .tt_sel(tt_sel4), .tt_data(tt_data4), .done(done4)
    );

    typedef struct {
        logic [3:0] sel;
        logic [7:0] data;
    } table_t;

    table_t sweep_tab[2];
    table_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int pcyc     = 0;
    int n_valid  = 0;
    int n_done   = 0;

    always @(posedge clk) pcyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every table pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (tt_valid) begin
            n_valid++;
            check("busy_during_emit", 32'(busy), 32'd1);
            if (sb_q.size() == 0) begin
                check("unexpected_tt_valid", 32'd1, 32'd0);
            end else begin
                table_t e;
                e = sb_q.pop_front();
                check("tt_sel", 32'(tt_sel), 32'(e.sel));
                check("tt_data", 32'(tt_data), 32'(e.data));
`ifdef SWEEP_COMPARE_EN
                check("tt_match", 32'(tt_match), 32'(e.data == exp_data));
`endif
            end
        end
        if (done) begin
            n_done++;
            check("busy_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic push_expected();
        for (int i = 0; i < 2; i++) sb_q.push_back(sweep_tab[i]);
    endtask

    task automatic start_sweep(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0    = pcyc;
        push_expected();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int t0, input int exp_lat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < exp_lat + 20 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check(name, 32'(pcyc - t0), 32'(exp_lat));
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    int  t0, v0, d0;
    bit  seen;

    initial begin
        sweep_tab[0] = '{sel: 4'hA, data: 8'hC3};
        sweep_tab[1] = '{sel: 4'hB, data: 8'h00};
        reset  = 1'b1;
        reset4 = 1'b1;
        start  = 1'b0;
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        reset4 = 1'b0;

        // Idle after reset: every output stays 0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({x, y, w, z, letra, busy, tt_valid, tt_sel, tt_data, done}), 32'd0);
        end
        check("idle4_outputs", {x4, y4, w4, z4, letra4, busy4, tt_valid4, tt_sel4, tt_data4}, 32'd0);
        check("idle4_done", 32'(done4), 32'd0);
        check("idle_no_pulses", 32'(n_valid + n_done), 32'd0);

        // Plain sweep with the default configuration.
        start_sweep(t0);
        check("busy_after_start", 32'(busy), 32'd1);
        check("letra_after_start", 32'(letra), 32'hA);
        wait_done("latency_plain", t0, 35);
`ifdef SWEEP_COMPARE_EN
        check("err_at_done", 32'(err), 32'd1);
`endif
        @(negedge clk);
        check("plain_valid_count", 32'(n_valid), 32'd2);
        check("plain_done_count", 32'(n_done), 32'd1);
        check("plain_queue_empty", 32'(sb_q.size()), 32'd0);
        check("hold_tt_sel", 32'(tt_sel), 32'hB);

        // Start pulsed mid-sweep at cycle 10 is ignored.
        v0 = n_valid;
        d0 = n_done;
        start_sweep(t0);
`ifdef SWEEP_COMPARE_EN
        check("err_cleared_on_start", 32'(err), 32'd0);
`endif
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("latency_ignored_start", t0, 35);
        repeat (4) @(negedge clk);
        check("ignored_valid_count", 32'(n_valid - v0), 32'd2);
        check("ignored_done_count", 32'(n_done - d0), 32'd1);
        check("ignored_busy", 32'(busy), 32'd0);

        // Reset at cycle 12 of a sweep.
        v0 = n_valid;
        d0 = n_done;
        start_sweep(t0);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs", 32'({x, y, w, z, letra, busy, tt_valid, tt_sel, tt_data, done}), 32'd0);
        sb_q.delete();
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("midreset_no_pulses", 32'((n_valid - v0) + (n_done - d0)), 32'd0);
        start_sweep(t0);
        wait_done("latency_after_reset", t0, 35);

        // Start held high: a second sweep starts from the next IDLE.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        t0    = pcyc;
        push_expected();
        push_expected();
        wait_done("latency_held_1", t0, 35);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                check("held_restart_cycle", 32'(pcyc - t0), 32'd37);
            end
        end
        if (!seen) check("held_restart_timeout", 32'd0, 32'd1);
        start = 1'b0;
        wait_done("latency_held_2", t0, 71);
        repeat (3) @(negedge clk);
        check("held_queue_empty", 32'(sb_q.size()), 32'd0);

        // Four-variable instance: s tied to z, SETTLE=2, single code F.
        @(negedge clk);
        start4 = 1'b1;
        t0     = pcyc;
        @(negedge clk);
        start4 = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (tt_valid4) begin
                seen = 1'b1;
                check("nv4_tt_sel", 32'(tt_sel4), 32'hF);
                check("nv4_tt_data", 32'(tt_data4), 32'hAAAA);
`ifdef SWEEP_COMPARE_EN
                check("nv4_tt_match", 32'(tt_match4), 32'd1);
`endif
            end
        end
        if (!seen) check("nv4_valid_timeout", 32'd0, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (done4) begin
                seen = 1'b1;
                check("nv4_latency", 32'(pcyc - t0), 32'd50);
                check("nv4_busy_at_done", 32'(busy4), 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) check("nv4_done_timeout", 32'd0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
